// File: rtl/stream_rr_fifo_arbiter.sv
// Round-robin arbiter that merges NUM_IN AXI-Stream producers into one StreamingFIFO input,
// granting fixed BURST-beat bursts only when the FIFO can absorb the whole burst.
module stream_rr_fifo_arbiter #(
   parameter int NUM_IN     = 4,
   parameter int WIDTH      = 8,
   parameter int BURST      = 4,
   parameter int FIFO_DEPTH = 4096,
   parameter int CNT_W      = 12,
   parameter int ID_W       = 2
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic [NUM_IN*WIDTH-1:0]   in_TDATA,
   input  logic [NUM_IN-1:0]         in_TVALID,
   output logic [NUM_IN-1:0]         in_TREADY,
   output logic [WIDTH-1:0]          out_TDATA,
   output logic                      out_TVALID,
   input  logic                      out_TREADY,
   output logic [ID_W-1:0]           out_TID,
   output logic                      out_TLAST,
   input  logic [CNT_W-1:0]          fifo_count,
   output logic                      busy
);

   localparam int BEAT_W = $clog2(BURST + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);
   // One extra bit so FIFO_DEPTH itself is representable in the occupancy compare.
   localparam logic [CNT_W:0] SPACE_LIM = (CNT_W + 1)'(FIFO_DEPTH - BURST);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_nx;
   logic [ID_W-1:0]   gnt, gnt_nx;
   logic [ID_W-1:0]   last_gnt, last_gnt_nx;
   logic [BEAT_W-1:0] beat, beat_nx;
   logic [ID_W-1:0]   pick;
   logic              found;
   logic              space_ok;

   assign space_ok = ({1'b0, fifo_count} <= SPACE_LIM);

   // Two ascending passes: streams above last_gnt first, then wrap to the rest.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (!found && in_TVALID[i] && (ID_W'(i) > last_gnt)) begin
            pick  = ID_W'(i);
            found = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (!found && in_TVALID[i] && (ID_W'(i) <= last_gnt)) begin
            pick  = ID_W'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      gnt_nx      = gnt;
      last_gnt_nx = last_gnt;
      beat_nx     = beat;
      in_TREADY   = '0;
      out_TDATA   = '0;
      out_TVALID  = 1'b0;
      out_TID     = '0;
      out_TLAST   = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            if ((|in_TVALID) && space_ok) begin
               gnt_nx   = pick;
               beat_nx  = '0;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            busy      = 1'b1;
            out_TID   = gnt;
            out_TLAST = (beat == LAST_BEAT);
            for (int unsigned i = 0; i < NUM_IN; i++) begin
               if (gnt == ID_W'(i)) begin
                  out_TDATA    = in_TDATA[i*WIDTH +: WIDTH];
                  out_TVALID   = in_TVALID[i];
                  in_TREADY[i] = out_TREADY;
               end
            end
            if (out_TVALID && out_TREADY) begin
               if (out_TLAST) begin
                  last_gnt_nx = gnt;
                  beat_nx     = '0;
                  state_nx    = IDLE;
               end else begin
                  beat_nx = beat + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state    <= IDLE;
         gnt      <= '0;
         last_gnt <= ID_W'(NUM_IN - 1);
         beat     <= '0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         last_gnt <= last_gnt_nx;
         beat     <= beat_nx;
      end
   end

endmodule

// File: tb/tb_stream_rr_fifo_arbiter.sv
// Self-checking bench for stream_rr_fifo_arbiter: directed scenarios plus random traffic,
// all compared against a burst-level round-robin reference model.
module tb_stream_rr_fifo_arbiter;

   localparam int NUM_IN     = 4;
   localparam int WIDTH      = 8;
   localparam int BURST      = 4;
   localparam int FIFO_DEPTH = 4096;
   localparam int CNT_W      = 12;
   localparam int ID_W       = 2;
   localparam int VW         = NUM_IN + 3 + ID_W + WIDTH;

   logic                    ap_clk = 1'b0;
   logic                    ap_rst;
   logic [NUM_IN*WIDTH-1:0] in_TDATA;
   logic [NUM_IN-1:0]       in_TVALID;
   logic [NUM_IN-1:0]       in_TREADY;
   logic [WIDTH-1:0]        out_TDATA;
   logic                    out_TVALID;
   logic                    out_TREADY;
   logic [ID_W-1:0]         out_TID;
   logic                    out_TLAST;
   logic [CNT_W-1:0]        fifo_count;
   logic                    busy;

   always #5 ap_clk = ~ap_clk;

   stream_rr_fifo_arbiter #(
      .NUM_IN(NUM_IN), .WIDTH(WIDTH), .BURST(BURST),
      .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .ID_W(ID_W)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
      .out_TDATA(out_TDATA), .out_TVALID(out_TVALID), .out_TREADY(out_TREADY),
      .out_TID(out_TID), .out_TLAST(out_TLAST),
      .fifo_count(fifo_count), .busy(busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: owner of the current burst (-1 = nobody), beats accepted so far,
   // and the last stream that completed a burst. p_* hold the values after the next edge.
   int m_owner = -1, m_beats = 0, m_last = NUM_IN - 1;
   int p_owner = -1, p_beats = 0, p_last = NUM_IN - 1;

   logic [VW-1:0] exp_v, act_v;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;
   beat_t obs[$];

   function automatic logic [NUM_IN*WIDTH-1:0] rnd_data();
      return (NUM_IN*WIDTH)'($urandom);
   endfunction

   task automatic apply(input logic rst, input logic [NUM_IN-1:0] v, input logic rdy,
                        input int cnt, input logic [NUM_IN*WIDTH-1:0] d);
      logic [WIDTH-1:0]  ed;
      logic [NUM_IN-1:0] er;
      logic              ev, el, eb;
      logic [ID_W-1:0]   eid;
      @(negedge ap_clk);
      m_owner = p_owner; m_beats = p_beats; m_last = p_last;
      ap_rst = rst; in_TVALID = v; out_TREADY = rdy; fifo_count = CNT_W'(cnt); in_TDATA = d;
      #1;
      ed = '0; er = '0; ev = 1'b0; el = 1'b0; eb = 1'b0; eid = '0;
      if (m_owner >= 0) begin
         ed          = d[m_owner*WIDTH +: WIDTH];
         ev          = v[m_owner];
         er[m_owner] = rdy;
         el          = (m_beats == BURST - 1);
         eb          = 1'b1;
         eid         = ID_W'(m_owner);
      end
      exp_v = {er, ev, el, eb, eid, ed};
      act_v = {in_TREADY, out_TVALID, out_TLAST, busy, out_TID, out_TDATA};
      if (out_TVALID === 1'b1 && out_TREADY === 1'b1)
         obs.push_back({out_TID, out_TDATA, out_TLAST});
      p_owner = m_owner; p_beats = m_beats; p_last = m_last;
      if (rst) begin
         p_owner = -1; p_beats = 0; p_last = NUM_IN - 1;
      end else if (m_owner < 0) begin
         if (v != 0 && cnt <= FIFO_DEPTH - BURST)
            for (int k = 1; k <= NUM_IN; k++)
               if (p_owner < 0 && v[(m_last + k) % NUM_IN]) p_owner = (m_last + k) % NUM_IN;
         p_beats = 0;
      end else if (v[m_owner] && rdy) begin
         p_beats = m_beats + 1;
         if (p_beats == BURST) begin
            p_last = m_owner; p_owner = -1; p_beats = 0;
         end
      end
   endtask

   task automatic test_reset();
      apply(1'b1, NUM_IN'($urandom), 1'b1, 0, rnd_data());
      apply(1'b1, NUM_IN'($urandom), 1'b1, 0, rnd_data());
      n_vec++;
      if (act_v !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected %h", act_v, {VW{1'b0}});
      end
   endtask

   task automatic test_round_robin();
      int idle_cyc = 0;
      obs.delete();
      for (int c = 0; c < 25; c++) begin
         apply(1'b0, 4'hF, 1'b1, 0, rnd_data());
         n_vec++;
         if (act_v !== exp_v) begin
            n_err++; $display("FAIL rr_cycle %0d: got %h expected %h", c, act_v, exp_v);
         end
         if (busy === 1'b0) idle_cyc++;
      end
      n_vec++;
      if (obs.size() != 20) begin
         n_err++; $display("FAIL rr_beats: got %0d expected 20", obs.size());
      end
      for (int b = 0; b < obs.size() && b < 20; b++) begin
         n_vec++;
         if (obs[b].id !== ID_W'((b / 4) % 4) || obs[b].last !== (b % 4 == 3)) begin
            n_err++;
            $display("FAIL rr_order beat %0d: got id %0d last %b expected id %0d last %b",
                     b, obs[b].id, obs[b].last, (b / 4) % 4, (b % 4 == 3));
         end
      end
      n_vec++;
      if (idle_cyc != 5) begin
         n_err++; $display("FAIL rr_bubbles: got %0d expected 5", idle_cyc);
      end
   endtask

   task automatic test_sole_requester();
      apply(1'b1, '0, 1'b0, 0, '0);
      obs.delete();
      for (int c = 0; c < 10; c++) begin
         apply(1'b0, 4'b0100, 1'b1, 0, rnd_data());
         n_vec++;
         if (act_v !== exp_v) begin
            n_err++; $display("FAIL sole_cycle %0d: got %h expected %h", c, act_v, exp_v);
         end
      end
      n_vec++;
      if (obs.size() != 8) begin
         n_err++; $display("FAIL sole_beats: got %0d expected 8", obs.size());
      end
      for (int b = 0; b < obs.size(); b++) begin
         n_vec++;
         if (obs[b].id !== 2'd2) begin
            n_err++; $display("FAIL sole_id beat %0d: got %0d expected 2", b, obs[b].id);
         end
      end
   endtask

   task automatic test_space();
      apply(1'b1, '0, 1'b0, 0, '0);
      obs.delete();
      for (int c = 0; c < 6; c++) begin
         apply(1'b0, 4'b0001, 1'b1, 4093, rnd_data());
         n_vec++;
         if (busy !== 1'b0 || in_TREADY !== 4'b0000 || act_v !== exp_v) begin
            n_err++; $display("FAIL space_full %0d: got %h expected %h", c, act_v, exp_v);
         end
      end
      apply(1'b0, 4'b0001, 1'b1, 4092, rnd_data());
      // Occupancy rising during the burst must not stall it.
      for (int c = 0; c < 6; c++) begin
         apply(1'b0, 4'b0001, 1'b1, 4095, rnd_data());
         n_vec++;
         if (act_v !== exp_v || busy !== (c < 4)) begin
            n_err++; $display("FAIL space_burst %0d: got %h expected %h", c, act_v, exp_v);
         end
      end
      n_vec++;
      if (obs.size() != 4 || (obs.size() == 4 && (obs[3].last !== 1'b1 || obs[0].id !== 2'd0))) begin
         n_err++; $display("FAIL space_beats: got %0d expected 4", obs.size());
      end
   endtask

   task automatic test_lock();
      logic [NUM_IN-1:0] v;
      apply(1'b1, '0, 1'b0, 0, '0);
      obs.delete();
      for (int c = 1; c <= 15; c++) begin
         v = (c <= 3 || c == 9 || c == 10) ? 4'b1010 : 4'b1000;
         apply(1'b0, v, 1'b1, 0, rnd_data());
         n_vec++;
         if (act_v !== exp_v) begin
            n_err++; $display("FAIL lock_cycle %0d: got %h expected %h", c, act_v, exp_v);
         end
         if (c >= 4 && c <= 8) begin
            n_vec++;
            if (busy !== 1'b1 || out_TID !== 2'd1 || in_TREADY !== 4'b0010 || out_TVALID !== 1'b0) begin
               n_err++;
               $display("FAIL lock_hold %0d: got busy %b id %0d rdy %b vld %b expected 1 1 0010 0",
                        c, busy, out_TID, in_TREADY, out_TVALID);
            end
         end
      end
      n_vec++;
      if (obs.size() != 8) begin
         n_err++; $display("FAIL lock_beats: got %0d expected 8", obs.size());
      end
      for (int b = 0; b < obs.size(); b++) begin
         n_vec++;
         if (obs[b].id !== ((b < 4) ? 2'd1 : 2'd3)) begin
            n_err++; $display("FAIL lock_order beat %0d: got %0d expected %0d", b, obs[b].id, (b < 4) ? 1 : 3);
         end
      end
   endtask

   task automatic test_tready_toggle();
      logic [NUM_IN*WIDTH-1:0] d;
      apply(1'b1, '0, 1'b0, 0, '0);
      obs.delete();
      for (int c = 0; c < 10; c++) begin
         d = rnd_data();
         d[WIDTH-1:0] = 8'hA0 + 8'(obs.size());
         apply(1'b0, (obs.size() < 4) ? 4'b0001 : 4'b0000, (c % 2 == 1), 0, d);
         n_vec++;
         if (act_v !== exp_v || (busy === 1'b1 && in_TREADY[0] !== out_TREADY)) begin
            n_err++; $display("FAIL toggle_cycle %0d: got %h expected %h", c, act_v, exp_v);
         end
      end
      n_vec++;
      if (obs.size() != 4) begin
         n_err++; $display("FAIL toggle_beats: got %0d expected 4", obs.size());
      end
      for (int b = 0; b < obs.size(); b++) begin
         n_vec++;
         if (obs[b].data !== 8'hA0 + 8'(b) || obs[b].last !== (b == 3)) begin
            n_err++;
            $display("FAIL toggle_data beat %0d: got %h last %b expected %h last %b",
                     b, obs[b].data, obs[b].last, 8'hA0 + 8'(b), (b == 3));
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      apply(1'b1, '0, 1'b0, 0, '0);
      for (int c = 0; c < 5; c++) apply(1'b0, 4'b0010, 1'b1, 0, rnd_data());
      apply(1'b0, 4'b1111, 1'b1, 0, rnd_data());
      apply(1'b0, 4'b1111, 1'b1, 0, rnd_data());
      apply(1'b1, 4'b1111, 1'b1, 0, rnd_data());
      apply(1'b0, 4'b1111, 1'b1, 0, rnd_data());
      n_vec++;
      if (in_TREADY !== 4'b0000 || out_TVALID !== 1'b0 || busy !== 1'b0 || act_v !== exp_v) begin
         n_err++; $display("FAIL midrst_outputs: got %h expected %h", act_v, {VW{1'b0}});
      end
      obs.delete();
      for (int c = 0; c < 4; c++) begin
         apply(1'b0, 4'b1111, 1'b1, 0, rnd_data());
         n_vec++;
         if (act_v !== exp_v) begin
            n_err++; $display("FAIL midrst_cycle %0d: got %h expected %h", c, act_v, exp_v);
         end
      end
      n_vec++;
      if (obs.size() != 4 || (obs.size() > 0 && obs[0].id !== 2'd0)) begin
         n_err++; $display("FAIL midrst_regrant: got %0d beats expected 4 from stream 0", obs.size());
      end
   endtask

   task automatic test_random();
      int cnt;
      for (int c = 0; c < 400; c++) begin
         cnt = ($urandom % 2 == 0) ? int'($urandom_range(4088, 4095)) : int'($urandom_range(0, 4095));
         apply(($urandom % 64) == 0, NUM_IN'($urandom), ($urandom % 4) != 0, cnt, rnd_data());
         n_vec++;
         if (act_v !== exp_v) begin
            n_err++; $display("FAIL random_cycle %0d: got %h expected %h", c, act_v, exp_v);
         end
      end
   endtask

   initial begin
      ap_rst = 1'b1; in_TVALID = '0; out_TREADY = 1'b0; fifo_count = '0; in_TDATA = '0;
      test_reset();
      test_round_robin();
      test_sole_requester();
      test_space();
      test_lock();
      test_tready_toggle();
      test_reset_mid_burst();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_rr_fifo_arbiter.md
Name: stream_rr_fifo_arbiter

Overview:
- Shares one StreamingFIFO input (Q_srl-based, exposes `count`) among NUM_IN AXI-Stream producers.
- Round-robin grants of fixed BURST beats per grant.
- A grant is issued only when the FIFO has room for a whole burst, so a granted burst never stalls on FIFO-full.
- Sits between the producer layers and the FIFO's in0_V_V interface.

Parameters:
- NUM_IN, 4, number of requesting streams (2..16).
- WIDTH, 8, data width per stream, in bits.
- BURST, 4, beats transferred per grant (1..256).
- FIFO_DEPTH, 4096, depth of the downstream FIFO.
- CNT_W, 12, width of fifo_count; equals clog2(FIFO_DEPTH).
- ID_W, 2, width of out_TID; equals max(1, clog2(NUM_IN)).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- in_TDATA  in  NUM_IN*WIDTH  packed producer data; stream i occupies bits [i*WIDTH +: WIDTH].
- in_TVALID  in  NUM_IN  per-stream valid.
- in_TREADY  out  NUM_IN  per-stream ready.
- out_TDATA  out  WIDTH  data to the FIFO's in0_V_V_TDATA.
- out_TVALID  out  1  valid to the FIFO.
- out_TREADY  in  1  FIFO in0_V_V_TREADY.
- out_TID  out  ID_W  index of the currently granted stream.
- out_TLAST  out  1  high on the final beat of a burst.
- fifo_count  in  CNT_W  FIFO occupancy (FIFO `count` output).
- busy  out  1  high while in GRANT.

Behaviour:
- Registers: state {IDLE, GRANT}, gnt (ID_W), last_gnt (ID_W), beat (clog2(BURST+1)).
- Reset values (on ap_rst): state=IDLE, gnt=0, last_gnt=NUM_IN-1, beat=0.
  - Hence the first grant goes to stream 0 if it is requesting.
  - Outputs in reset: in_TREADY=0, out_TVALID=0, out_TLAST=0, busy=0, out_TID=0, out_TDATA=0.
- space_ok = (fifo_count <= FIFO_DEPTH - BURST), unsigned compare, widened to CNT_W+1 bits so FIFO_DEPTH does not overflow.
- IDLE:
  - If any in_TVALID and space_ok: pick the first i with in_TVALID[i]=1, searching from last_gnt+1 upward and wrapping modulo NUM_IN.
  - Load gnt=i, beat=0, go to GRANT.
  - Otherwise stay in IDLE.
  - All in_TREADY=0 and out_TVALID=0 in IDLE. Every grant therefore costs exactly one bubble cycle.
- GRANT datapath: combinational, zero latency.
  - out_TDATA = in_TDATA[gnt], out_TVALID = in_TVALID[gnt], out_TID = gnt.
  - in_TREADY[gnt] = out_TREADY; all other in_TREADY bits = 0.
  - out_TLAST = (beat == BURST-1).
  - busy = 1.
- Handshake: out_TVALID & out_TREADY.
  - On a handshake with beat < BURST-1: beat++.
  - On a handshake with beat == BURST-1: last_gnt=gnt, beat=0, go to IDLE.
- Grant lock:
  - If the granted stream drops valid mid-burst, the grant is held: no timeout, no preemption.
  - Other requesters wait.
  - out_TVALID follows the granted stream's valid.
- space_ok is sampled only in IDLE. fifo_count changes during GRANT are ignored.
- Only the arbiter writes the FIFO, so the burst is guaranteed to fit.
- Fairness: after a burst from stream k, a requesting stream k+1 (mod NUM_IN) wins over all others. Worst-case wait is (NUM_IN-1)*(BURST+1) accepted-beat cycles plus stalls.
- Simultaneous events:
  - A requester asserting valid in the same cycle as a grant decision is eligible.
  - A handshake on the last beat and a new request in the same cycle: the new grant is decided in the following IDLE cycle.
- Reset mid-burst: the burst is abandoned immediately and all outputs take their reset values the next cycle. No partial-burst recovery; the FIFO contents are the FIFO's concern.
- BURST=1: every beat is last; out_TLAST is constant 1 in GRANT.
- Non-granted in_TDATA values have no effect.
- Unused out_TDATA in IDLE is driven 0.

Test Plan (NUM_IN=4, WIDTH=8, BURST=4, FIFO_DEPTH=4096):
- Reset, then all four streams valid continuously, out_TREADY=1, fifo_count=0 -> grants in order 0,1,2,3,0; each burst is 4 beats with TLAST on the 4th; one bubble between bursts; out_TID matches.
- Only stream 2 valid after reset -> first grant is 2; after its burst, stream 2 is granted again (sole requester) after one IDLE cycle.
- fifo_count=4093 with stream 0 valid -> no grant; busy=0 and in_TREADY=0. Drop fifo_count to 4092 -> grant the next cycle, 4 beats transferred.
- Stream 1 granted; drop in_TVALID[1] after beat 2 for 5 cycles while stream 3 is valid -> grant held, beat stays at 2, stream 3 not served; resume -> beats 3,4 complete, then stream 3 is granted.
- out_TREADY toggled 1,0,1,0 during a burst with data 0xA0..0xA3 -> exactly 4 accepted beats, in order; TLAST only on the beat carrying 0xA3; in_TREADY mirrors out_TREADY.
- Assert ap_rst during beat 2 of a burst -> next cycle all in_TREADY=0, out_TVALID=0, busy=0; the subsequent first grant goes to the lowest-index valid stream.
